// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Imported by the FIFO-fed transmitter and its bench.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int UART_FRAME_BITS = 10;
  localparam int CLKS_PER_BIT_DEFAULT = 87;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake from the processing core into the
// UART transmit stage.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              ready;

  modport master (
    output data_in,
    output data_valid,
    input  ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count.
// Head entry is presented combinationally on dout.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset, pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by a valid/ready
// byte handshake; frames run back to back while queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  in_if,
  output logic           tx,
  output logic           busy,
  output logic           overflow
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state;
  tx_state_t         state_n;
  logic [BW-1:0]     baud;
  logic [BW-1:0]     baud_n;
  logic [IW-1:0]     bit_idx;
  logic [IW-1:0]     bit_n;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_n;
  logic              tx_n;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              wrap;

  assign in_if.ready = ~full;
  assign push        = in_if.data_valid & ~full;
  assign wrap        = (baud == BW'(CLKS_PER_BIT - 1));
  assign busy        = (state != IDLE) | (count != '0);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_if.data_in),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Frame sequencing, baud timing and the registered line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
      overflow <= overflow | (in_if.data_valid & full);
    end
  end

  // Next-state, pop request and the level tx takes next edge.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    tx_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        tx_n   = 1'b0;
        baud_n = wrap ? '0 : baud + BW'(1);
        if (wrap) begin
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        tx_n   = shift[0];
        baud_n = wrap ? '0 : baud + BW'(1);
        if (wrap) begin
          shift_n = shift >> 1;
          if (bit_idx == IW'(DATA_W - 1)) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + IW'(1);
          end
        end
      end
      STOP: begin
        tx_n   = 1'b1;
        baud_n = wrap ? '0 : baud + BW'(1);
        if (wrap) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
    endcase
  end

endmodule
